// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetch PC and instruction, builds the link address, flags AdEL on fetch.
// Optional performance counters (stall_cnt, bubble_cnt) are enabled by defining IF_ID_PERF_CNT_EN.
module if_id_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_SIZE  = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        exc_d,
  output logic [4:0]  excode_d
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] r_pc;
  logic [31:0] r_pc8;
  logic [31:0] r_instr;
  logic        r_valid;
  logic        r_exc;
  logic [4:0]  r_excode;

  logic [32:0] w_im_end;
  logic        w_err;

  // Fetch address check; the window end is kept in 33 bits so a window reaching 2^32 does not wrap.
  always_comb begin
    w_im_end = {1'b0, IM_BASE} + {1'b0, IM_SIZE};
    w_err    = 1'b0;
    if ((pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || ({1'b0, pc_f} >= w_im_end)) begin
      w_err = 1'b1;
    end else begin
      w_err = 1'b0;
    end
  end

  // Pipeline state: reset > hold > flush > capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_pc8    <= RESET_PC + 32'd8;
      r_instr  <= 32'd0;
      r_valid  <= 1'b0;
      r_exc    <= 1'b0;
      r_excode <= 5'd0;
    end else if (!en) begin
      r_pc     <= r_pc;
      r_pc8    <= r_pc8;
      r_instr  <= r_instr;
      r_valid  <= r_valid;
      r_exc    <= r_exc;
      r_excode <= r_excode;
    end else if (flush) begin
      // The bubble keeps pc_f so an exception taken on it still has a meaningful EPC.
      r_pc     <= pc_f;
      r_pc8    <= pc_f + 32'd8;
      r_instr  <= 32'd0;
      r_valid  <= 1'b0;
      r_exc    <= 1'b0;
      r_excode <= 5'd0;
    end else if (w_err) begin
      r_pc     <= pc_f;
      r_pc8    <= pc_f + 32'd8;
      r_instr  <= 32'd0;
      r_valid  <= 1'b1;
      r_exc    <= 1'b1;
      r_excode <= EXC_ADEL;
    end else begin
      r_pc     <= pc_f;
      r_pc8    <= pc_f + 32'd8;
      r_instr  <= instr_f;
      r_valid  <= 1'b1;
      r_exc    <= 1'b0;
      r_excode <= 5'd0;
    end
  end

  assign pc_d     = r_pc;
  assign pc8_d    = r_pc8;
  assign instr_d  = r_instr;
  assign valid_d  = r_valid;
  assign exc_d    = r_exc;
  assign excode_d = r_excode;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  // Stall and bubble event counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt  <= 32'd0;
      r_bubble_cnt <= 32'd0;
    end else if (!en) begin
      r_stall_cnt  <= r_stall_cnt + 32'd1;
      r_bubble_cnt <= r_bubble_cnt;
    end else if (flush) begin
      r_stall_cnt  <= r_stall_cnt;
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end else begin
      r_stall_cnt  <= r_stall_cnt;
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
